// File: rtl/apb_cfg_seq.sv
// apb_cfg_seq: replays a parameterised APB write table after reset or start, optionally reading each entry back.
module apb_cfg_seq #(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter logic [NUM_REGS*ADDR_W-1:0] INIT_ADDR = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] INIT_DATA = '0,
   parameter int VERIFY = 0,
   parameter int TIMEOUT = 255,
   parameter int AUTO_START = 1
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              start,
   input  logic              pready,
   input  logic              pslverr,
   input  logic [DATA_W-1:0] prdata,
   output logic              pselx,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              config_done,
   output logic              config_err,
   output logic [1:0]        err_code,
   output logic [4:0]        err_index
);
   typedef enum logic [2:0] {IDLE, GAP, SETUP, ACCESS, RD_SETUP, RD_ACCESS, DONE, ERROR} state_t;
   localparam logic [4:0] LAST = 5'(NUM_REGS - 1);
   localparam logic [9:0] TMO = 10'(TIMEOUT);
   state_t state, state_n;
   logic [4:0] idx, idx_n;
   logic [9:0] wcnt, wcnt_n;
   logic [1:0] code, code_n;
   logic wr_d, en_d, bus_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge pclk)
      if (presetn) begin
         state <= IDLE;
         idx <= '0;
         wcnt <= '0;
         code <= '0;
         pselx <= 1'b0;
         penable <= 1'b0;
         pwrite <= 1'b0;
         paddr <= '0;
         pwdata <= '0;
         config_done <= 1'b0;
         config_err <= 1'b0;
         err_code <= '0;
         err_index <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         wcnt <= wcnt_n;
         code <= code_n;
         pselx <= bus_d;
         penable <= en_d;
         pwrite <= wr_d;
         paddr <= addr_d;
         pwdata <= data_d;
         config_done <= state_n == DONE;
         config_err <= state_n == ERROR;
         err_code <= state_n == ERROR ? code_n : 2'b00;
         err_index <= state_n == ERROR ? idx_n : 5'd0;
      end

   always_comb begin
      state_n = state;
      idx_n = idx;
      wcnt_n = wcnt;
      code_n = code;
      case (state)
         IDLE:
            if (AUTO_START != 0 || start) begin
               state_n = GAP;
               idx_n = '0;
            end
         GAP: state_n = SETUP;
         SETUP: begin
            state_n = ACCESS;
            wcnt_n = '0;
         end
         RD_SETUP: begin
            state_n = RD_ACCESS;
            wcnt_n = '0;
         end
         ACCESS, RD_ACCESS:
            if (!pready) begin
               if (wcnt == TMO) begin
                  state_n = ERROR;
                  code_n = 2'b10;
               end else
                  wcnt_n = wcnt + 10'd1;
            end else if (pslverr) begin
               state_n = ERROR;
               code_n = 2'b01;
            end else if (state == RD_ACCESS && prdata != INIT_DATA[idx*DATA_W +: DATA_W]) begin
               state_n = ERROR;
               code_n = 2'b11;
            end else if (state == ACCESS && VERIFY != 0)
               state_n = RD_SETUP;
            else if (idx == LAST)
               state_n = DONE;
            else begin
               idx_n = idx + 5'd1;
               state_n = GAP;
            end
         default:
            if (start) begin
               state_n = GAP;
               idx_n = '0;
               code_n = '0;
            end
      endcase
   end

   always_comb begin
      wr_d = state_n == SETUP || state_n == ACCESS;
      en_d = state_n == ACCESS || state_n == RD_ACCESS;
      bus_d = wr_d || state_n == RD_SETUP || state_n == RD_ACCESS;
      addr_d = bus_d ? INIT_ADDR[idx_n*ADDR_W +: ADDR_W] : '0;
      data_d = wr_d ? INIT_DATA[idx_n*DATA_W +: DATA_W] : '0;
   end
endmodule

// File: tb/tb_apb_cfg_seq.sv
// tb_apb_cfg_seq: scenario table plus transfer scoreboard for a plain (g=0) and a verifying, start-triggered (g=1) sequencer.
module tb_apb_cfg_seq;
   localparam logic [7:0] A [5] = '{8'h00, 8'h01, 8'h12, 8'h13, 8'h14};
   localparam logic [31:0] D [5] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
   localparam logic [39:0] IA = {A[4], A[3], A[2], A[1], A[0]};
   localparam logic [159:0] ID = {D[4], D[3], D[2], D[1], D[0]};

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } xfer_t;

   typedef struct {
      int dut, stall_idx, stall_cyc, slv_idx, bad_idx;
      int n_ok, tail, left;
      logic done, err;
      logic [1:0] code;
      logic [4:0] eidx;
      int cyc;
   } vec_t;

   logic pclk;
   logic [1:0] presetn_v, start_v, pready_v, pslverr_v;
   logic [1:0] pselx_v, penable_v, pwrite_v, config_done_v, config_err_v;
   logic [31:0] prdata_v [2];
   logic [7:0] paddr_v [2];
   logic [31:0] pwdata_v [2];
   logic [1:0] err_code_v [2];
   logic [4:0] err_index_v [2];

   xfer_t q[$];
   vec_t tv[7];
   int n_vec, n_bad;
   int stall_idx, stall_cyc, slv_idx, bad_idx;
   int acc [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      apb_cfg_seq #(.NUM_REGS(5), .ADDR_W(8), .DATA_W(32), .INIT_ADDR(IA), .INIT_DATA(ID),
                    .VERIFY(g), .TIMEOUT(4), .AUTO_START(1 - g)) u_dut (
         .pclk(pclk), .presetn(presetn_v[g]), .start(start_v[g]), .pready(pready_v[g]),
         .pslverr(pslverr_v[g]), .prdata(prdata_v[g]), .pselx(pselx_v[g]), .penable(penable_v[g]),
         .pwrite(pwrite_v[g]), .paddr(paddr_v[g]), .pwdata(pwdata_v[g]),
         .config_done(config_done_v[g]), .config_err(config_err_v[g]),
         .err_code(err_code_v[g]), .err_index(err_index_v[g]));
   end

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic int ent(input logic [7:0] a);
      for (int i = 0; i < 5; i++)
         if (A[i] == a) return i;
      return -1;
   endfunction

   function automatic void push_exp(input int n, input int tail, input int ver);
      for (int i = 0; i < n; i++) begin
         q.push_back('{1'b1, A[i], D[i]});
         if (ver != 0) q.push_back('{1'b0, A[i], 32'h0});
      end
      if (tail > 0) q.push_back('{1'b1, A[n], D[n]});
      if (tail > 1) q.push_back('{1'b0, A[n], 32'h0});
   endfunction

   task automatic check_idle(input int d, input string p);
      check({p, "_psel"}, pselx_v[d], 0);
      check({p, "_pen"}, penable_v[d], 0);
      check({p, "_pwrite"}, pwrite_v[d], 0);
      check({p, "_paddr"}, paddr_v[d], 0);
      check({p, "_pwdata"}, pwdata_v[d], 0);
      check({p, "_done"}, config_done_v[d], 0);
      check({p, "_err"}, config_err_v[d], 0);
      check({p, "_code"}, err_code_v[d], 0);
      check({p, "_index"}, err_index_v[d], 0);
   endtask

   task automatic wait_end(input int d, input int c0, input int poke, output int cyc);
      cyc = c0;
      while (!(config_done_v[d] || config_err_v[d]) && cyc < 400) begin
         @(negedge pclk);
         cyc++;
         start_v[d] = (cyc == poke);
      end
      start_v[d] = 1'b0;
      check("end_bound", cyc < 400, 1);
   endtask

   // APB slave model and scoreboard: answers each ACCESS cycle and checks it against the queue head.
   initial begin
      int e;
      pready_v = 2'b11;
      pslverr_v = 2'b00;
      prdata_v[0] = '0;
      prdata_v[1] = '0;
      acc[0] = 0;
      acc[1] = 0;
      forever begin
         @(negedge pclk);
         for (int d = 0; d < 2; d++) begin
            e = ent(paddr_v[d]);
            prdata_v[d] = (pselx_v[d] && e >= 0) ? ((e == bad_idx) ? ~D[e] : D[e]) : 32'h0;
            if (pselx_v[d] && penable_v[d]) begin
               pready_v[d] = !(e == stall_idx && acc[d] < stall_cyc);
               pslverr_v[d] = pready_v[d] && e == slv_idx;
               acc[d]++;
               if (q.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL xfer_unexpected: got addr %0h, required no transfer", paddr_v[d]);
               end else begin
                  check("xfer_wr", pwrite_v[d], q[0].wr);
                  check("xfer_addr", paddr_v[d], q[0].addr);
                  check("xfer_data", pwdata_v[d], q[0].data);
                  if (pready_v[d]) void'(q.pop_front());
               end
            end else begin
               acc[d] = 0;
               pready_v[d] = 1'b1;
               pslverr_v[d] = 1'b0;
            end
         end
      end
   end

   initial begin
      int d, cyc, k;
      n_vec = 0;
      n_bad = 0;
      stall_idx = -1;
      stall_cyc = 0;
      slv_idx = -1;
      bad_idx = -1;
      tv[0] = '{0, -1, 0, -1, -1, 5, 0, 0, 1'b1, 1'b0, 2'd0, 5'd0, 16};
      tv[1] = '{0, 2, 3, -1, -1, 5, 0, 0, 1'b1, 1'b0, 2'd0, 5'd0, 19};
      tv[2] = '{0, 1, 1000, -1, -1, 1, 1, 1, 1'b0, 1'b1, 2'd2, 5'd1, -1};
      tv[3] = '{0, -1, 0, 0, -1, 0, 1, 0, 1'b0, 1'b1, 2'd1, 5'd0, 4};
      tv[4] = '{0, -1, 0, 4, -1, 4, 1, 0, 1'b0, 1'b1, 2'd1, 5'd4, 16};
      tv[5] = '{1, -1, 0, -1, -1, 5, 0, 0, 1'b1, 1'b0, 2'd0, 5'd0, 26};
      tv[6] = '{1, -1, 0, -1, 3, 3, 2, 0, 1'b0, 1'b1, 2'd3, 5'd3, 21};
      presetn_v = 2'b11;
      start_v = 2'b00;
      repeat (3) @(negedge pclk);
      check_idle(0, "rst0");
      check_idle(1, "rst1");
      for (int i = 0; i < 7; i++) begin
         d = tv[i].dut;
         stall_idx = tv[i].stall_idx;
         stall_cyc = tv[i].stall_cyc;
         slv_idx = tv[i].slv_idx;
         bad_idx = tv[i].bad_idx;
         presetn_v = 2'b11;
         repeat (2) @(negedge pclk);
         q.delete();
         push_exp(tv[i].n_ok, tv[i].tail, d);
         presetn_v[d] = 1'b0;
         if (d == 1) begin
            repeat (3) @(negedge pclk);
            check($sformatf("v%0d_noauto", i), pselx_v[1], 0);
            start_v[1] = 1'b1;
            @(negedge pclk);
            start_v[1] = 1'b0;
            wait_end(d, 1, -1, cyc);
         end else
            wait_end(d, 0, -1, cyc);
         check($sformatf("v%0d_done", i), config_done_v[d], tv[i].done);
         check($sformatf("v%0d_err", i), config_err_v[d], tv[i].err);
         check($sformatf("v%0d_code", i), err_code_v[d], tv[i].code);
         check($sformatf("v%0d_index", i), err_index_v[d], tv[i].eidx);
         check($sformatf("v%0d_psel", i), pselx_v[d], 0);
         check($sformatf("v%0d_pen", i), penable_v[d], 0);
         check($sformatf("v%0d_paddr", i), paddr_v[d], 0);
         check($sformatf("v%0d_pwdata", i), pwdata_v[d], 0);
         if (tv[i].cyc >= 0) check($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
         check($sformatf("v%0d_left", i), q.size(), tv[i].left);
      end
      // Restart from ERROR clears the status, reruns from entry 0 and ignores a mid-run start.
      bad_idx = -1;
      q.delete();
      push_exp(5, 0, 1);
      start_v[1] = 1'b1;
      @(negedge pclk);
      start_v[1] = 1'b0;
      check("rerun_err_clr", config_err_v[1], 0);
      check("rerun_code_clr", err_code_v[1], 0);
      check("rerun_index_clr", err_index_v[1], 0);
      check("rerun_gap_psel", pselx_v[1], 0);
      wait_end(1, 1, 8, cyc);
      check("rerun_done", config_done_v[1], 1);
      check("rerun_cycles", cyc, 26);
      check("rerun_left", q.size(), 0);
      // Reset during a stalled ACCESS, with start also high, then auto-start again.
      presetn_v = 2'b11;
      stall_idx = 2;
      stall_cyc = 3;
      repeat (2) @(negedge pclk);
      q.delete();
      push_exp(5, 0, 0);
      presetn_v[0] = 1'b0;
      k = 0;
      while (!(pselx_v[0] && penable_v[0] && paddr_v[0] == 8'h12) && k < 100) begin
         @(negedge pclk);
         k++;
      end
      check("mid_reach", k < 100, 1);
      presetn_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge pclk);
      check_idle(0, "midrst");
      start_v[0] = 1'b0;
      stall_idx = -1;
      q.delete();
      push_exp(5, 0, 0);
      presetn_v[0] = 1'b0;
      wait_end(0, 0, -1, cyc);
      check("reauto_done", config_done_v[0], 1);
      check("reauto_cycles", cyc, 16);
      check("reauto_left", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/apb_cfg_seq.md
APB_CFG_SEQ -- requirements
Module: apb_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of table writes (1..32).
REQ-002 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-003 SHALL have parameter DATA_W, default 32, APB data width.
REQ-004 SHALL have parameter INIT_ADDR, default 0, NUM_REGS*ADDR_W flat vector, entry i at bits [i*ADDR_W +: ADDR_W].
REQ-005 SHALL have parameter INIT_DATA, default 0, NUM_REGS*DATA_W flat vector, same packing.
REQ-006 SHALL have parameter VERIFY, default 0, 1 = read back and compare each entry after its write.
REQ-007 SHALL have parameter TIMEOUT, default 255, maximum ACCESS wait cycles (1..1023).
REQ-008 SHALL have parameter AUTO_START, default 1, 1 = run the sequence once after reset without start.
REQ-009 pclk  in  1  sole clock, all logic on rising edge.
REQ-010 presetn  in  1  reset, synchronous, active-high (despite the name).
REQ-011 start  in  1  single-cycle pulse, (re)runs the sequence from entry 0.
REQ-012 pready  in  1  APB slave ready.
REQ-013 pslverr  in  1  APB slave error, sampled only when pready=1 in ACCESS.
REQ-014 prdata  in  DATA_W  APB read data.
REQ-015 pselx, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-017 config_done  out  1  sequence completed without error.
REQ-018 config_err  out  1  sequence aborted.
REQ-019 err_code  out  2  01 = pslverr, 10 = timeout, 11 = verify mismatch, 00 = none.
REQ-020 err_index  out  5  table index of the failing entry.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 FSM states: IDLE, GAP, SETUP, ACCESS, RD_SETUP, RD_ACCESS, DONE, ERROR.
REQ-023 IDLE SHALL go to GAP with index=0 on the cycle after reset if AUTO_START=1, else on a start pulse.
REQ-024 GAP SHALL last 1 cycle with pselx=penable=pwrite=0, paddr=0, pwdata=0, then enter SETUP.
REQ-025 SETUP SHALL last 1 cycle: pselx=1, penable=0, pwrite=1, paddr=INIT_ADDR[index], pwdata=INIT_DATA[index].
REQ-026 ACCESS SHALL set penable=1 and hold addr, data and pwrite; it is stable while pready=0.
REQ-027 When pready=1 in ACCESS: pslverr=1 SHALL go to ERROR with code 01; else if VERIFY=1 go to RD_SETUP; else advance.
REQ-028 RD_SETUP/RD_ACCESS SHALL mirror SETUP/ACCESS with pwrite=0 and pwdata=0.
REQ-029 When pready=1 in RD_ACCESS: pslverr SHALL give code 01; prdata != INIT_DATA[index] SHALL give code 11; else advance.
REQ-030 Advance: if index==NUM_REGS-1, go to DONE; else index+1 and go to GAP.
REQ-031 Wait counter SHALL clear on SETUP/RD_SETUP and count ACCESS/RD_ACCESS cycles with pready=0.
REQ-032 Wait counter reaching TIMEOUT with pready still 0 SHALL go to ERROR with code 10.
REQ-033 On entering DONE or ERROR: pselx=penable=0, paddr=0, pwdata=0 on the next cycle.
REQ-034 DONE SHALL hold config_done=1. ERROR SHALL hold config_err=1, err_code, and err_index=index.
REQ-035 A start pulse in DONE or ERROR SHALL clear config_done, config_err, err_code and err_index, set index=0, and enter GAP.
REQ-036 A start pulse in any other non-IDLE state SHALL be ignored.
REQ-037 Transfer length without wait states: 3 cycles per write (GAP, SETUP, ACCESS); with VERIFY=1, 5 cycles per entry.
REQ-038 Total cycles for NUM_REGS=5, VERIFY=0, zero wait: 15 cycles from leaving IDLE to DONE.

Reset
REQ-039 presetn=1 at a clock edge SHALL force IDLE, index=0, wait counter=0, and all outputs 0, including mid-transfer.
REQ-040 Reset SHALL take precedence over start and pready in the same cycle.
REQ-041 After presetn falls, AUTO_START behaviour SHALL re-apply.

Verification
REQ-042 Defaults, pready tied 1: release reset -> 5 writes to 0x00, 0x01, 0x12, 0x13, 0x14, each pselx high for 2 cycles; config_done=1 after 15 cycles.
REQ-043 pready low for 3 cycles on entry 2 -> ACCESS stretched to 4 cycles with addr/data stable; config_done=1 still reached.
REQ-044 TIMEOUT=4, pready held 0 on entry 1 -> config_err=1, err_code=10, err_index=1, pselx=0.
REQ-045 VERIFY=1, prdata differs on entry 3 -> err_code=11, err_index=3; then start -> errors clear and the sequence reruns from 0x00.
REQ-046 pslverr=1 with pready=1 on entry 0 -> err_code=01; presetn asserted mid-ACCESS -> all outputs 0 next cycle.
